// File: rtl/id_fetch_queue_pkg.sv
// Shared definitions for the IF->ID instruction queue.
package id_fetch_queue_pkg;

  localparam int unsigned INST_W      = 32;
  localparam int unsigned DEF_PC_W    = 64;
  localparam int unsigned DEF_FETCH_W = 64;
  localparam int unsigned DEF_DEPTH   = 4;

  localparam int unsigned SLOTS  = DEF_FETCH_W / INST_W;
  localparam int unsigned SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned PTR_W  = $clog2(DEF_DEPTH);

  // One queued fetch word with the PC of its first wanted instruction.
  typedef struct packed {
    logic [DEF_PC_W-1:0]    pc;
    logic [DEF_FETCH_W-1:0] word;
  } fq_entry_t;

  // Number of 32-bit instruction slots in a fetch word.
  function automatic int unsigned fq_slots(input int unsigned fetch_w);
    return fetch_w / INST_W;
  endfunction

  // Bit width able to index n items; never below 1 so vectors stay legal.
  function automatic int unsigned fq_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/id_fetch_queue_fq_store.sv
// Entry storage for the fetch queue: one write port, one async read port.
module fq_store
  import id_fetch_queue_pkg::*;
#(
  parameter int unsigned PC_W    = DEF_PC_W,
  parameter int unsigned FETCH_W = DEF_FETCH_W,
  parameter int unsigned DEPTH   = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [fq_idx_w(DEPTH)-1:0] wr_ptr,
  input  logic [PC_W-1:0]            wr_pc,
  input  logic [FETCH_W-1:0]         wr_word,
  input  logic [fq_idx_w(DEPTH)-1:0] rd_ptr,
  output logic [PC_W-1:0]            rd_pc,
  output logic [FETCH_W-1:0]         rd_word
);

  logic [PC_W+FETCH_W-1:0] mem [DEPTH];

  // Write the incoming {pc, word} into the slot at wr_ptr.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= {wr_pc, wr_word};
  end

  // Head entry is read combinationally so it is visible the cycle after the write.
  always_comb begin
    {rd_pc, rd_word} = mem[rd_ptr];
  end

endmodule

// File: rtl/id_fetch_queue.sv
// Instruction queue between IF and ID: buffers fetch words and unpacks them
// into one 32-bit instruction per cycle over a valid/ready handshake.
module id_fetch_queue
  import id_fetch_queue_pkg::*;
#(
  parameter int unsigned PC_W    = DEF_PC_W,
  parameter int unsigned FETCH_W = DEF_FETCH_W,
  parameter int unsigned DEPTH   = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [FETCH_W-1:0]       in_word,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [INST_W-1:0]        out_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned N_SLOTS   = fq_slots(FETCH_W);
  localparam int unsigned SLOT_BITS = fq_idx_w(N_SLOTS);
  localparam int unsigned PTR_BITS  = fq_idx_w(DEPTH);
  localparam int unsigned CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [SLOT_BITS-1:0] LAST_SLOT = SLOT_BITS'(N_SLOTS - 1);

  logic [PTR_BITS-1:0]  wr_ptr, rd_ptr;
  logic [SLOT_BITS-1:0] sub, s0, slot;
  logic [PC_W-1:0]      head_pc;
  logic [FETCH_W-1:0]   head_word;
  logic                 push, fire, pop, is_last;

  fq_store #(
    .PC_W    (PC_W),
    .FETCH_W (FETCH_W),
    .DEPTH   (DEPTH)
  ) u_store (
    .clk     (clk),
    .we      (push),
    .wr_ptr  (wr_ptr),
    .wr_pc   (in_pc),
    .wr_word (in_word),
    .rd_ptr  (rd_ptr),
    .rd_pc   (head_pc),
    .rd_word (head_word)
  );

  // Starting slot comes from the PC's byte offset within the fetch word.
  if (N_SLOTS > 1) begin : g_multi_slot
    assign s0 = head_pc[$clog2(FETCH_W/8)-1:2];
  end else begin : g_single_slot
    assign s0 = '0;
  end

  // Handshake, slot selection and presented instruction.
  always_comb begin
    in_ready  = rst_n && (count != CNT_W'(DEPTH));
    out_valid = rst_n && (count != '0) && !flush;
    push      = in_valid && in_ready && !flush;
    slot      = s0 + sub;
    is_last   = (slot == LAST_SLOT);
    fire      = out_valid && out_ready;
    pop       = fire && is_last;
    out_pc    = '0;
    out_inst  = '0;
    if (out_valid) begin
      out_pc   = head_pc + (PC_W'(sub) << 2);
      out_inst = head_word[INST_W*slot +: INST_W];
    end
  end

  // Pointers, occupancy and sub-slot counter; flush clears like reset.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      sub    <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_BITS'(1);
        sub    <= '0;
      end else if (fire) begin
        sub <= sub + SLOT_BITS'(1);
      end
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count <= CNT_W'(DEPTH));

  a_push_ready: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> in_ready);

  a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (!out_valid || ($stable(out_pc) && $stable(out_inst))));

endmodule

// File: tb/tb_id_fetch_queue.sv
// Bench for id_fetch_queue: directed scenarios plus random traffic, checked
// against an instruction-stream reference model on two configurations.
module tb_id_fetch_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Common stimulus, routed to the selected DUT.
  logic         sel;
  logic         rst_n, flush, in_valid, out_ready;
  logic [63:0]  in_pc;
  logic [127:0] in_word;

  // DUT A: defaults (FETCH_W=64, DEPTH=4)
  logic        a_rst_n, a_flush, a_in_valid, a_out_ready, a_in_ready, a_out_valid;
  logic [63:0] a_in_pc, a_in_word, a_out_pc;
  logic [31:0] a_out_inst;
  logic [2:0]  a_count;

  // DUT B: FETCH_W=128, DEPTH=2
  logic         b_rst_n, b_flush, b_in_valid, b_out_ready, b_in_ready, b_out_valid;
  logic [63:0]  b_in_pc, b_out_pc;
  logic [127:0] b_in_word;
  logic [31:0]  b_out_inst;
  logic [1:0]   b_count;

  assign a_rst_n     = !sel && rst_n;
  assign a_flush     = !sel && flush;
  assign a_in_valid  = !sel && in_valid;
  assign a_out_ready = !sel && out_ready;
  assign a_in_pc     = in_pc;
  assign a_in_word   = in_word[63:0];

  assign b_rst_n     = sel && rst_n;
  assign b_flush     = sel && flush;
  assign b_in_valid  = sel && in_valid;
  assign b_out_ready = sel && out_ready;
  assign b_in_pc     = in_pc;
  assign b_in_word   = in_word;

  id_fetch_queue dut_a (
    .clk(clk), .rst_n(a_rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_pc(a_in_pc), .in_word(a_in_word),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pc(a_out_pc),
    .out_inst(a_out_inst), .count(a_count)
  );

  id_fetch_queue #(.PC_W(64), .FETCH_W(128), .DEPTH(2)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pc(b_in_pc), .in_word(b_in_word),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc),
    .out_inst(b_out_inst), .count(b_count)
  );

  logic        o_in_ready, o_out_valid;
  logic [63:0] o_out_pc;
  logic [31:0] o_out_inst;
  logic [2:0]  o_count;
  assign o_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign o_out_valid = sel ? b_out_valid : a_out_valid;
  assign o_out_pc    = sel ? b_out_pc    : a_out_pc;
  assign o_out_inst  = sel ? b_out_inst  : a_out_inst;
  assign o_count     = sel ? {1'b0, b_count} : a_count;

  // Reference model: the pending instruction stream, one entry per instruction.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    bit          last;
  } inst_t;
  inst_t       mq[$];
  int unsigned m_depth, m_slots;
  int unsigned n_assert, n_fail;

  function automatic int unsigned m_count();
    int unsigned n = 0;
    foreach (mq[i]) if (mq[i].last) n++;
    return n;
  endfunction

  task automatic push_word(input logic [63:0] pc, input logic [127:0] word);
    inst_t e;
    int unsigned s0 = int'((pc >> 2) % 64'(m_slots));
    for (int unsigned k = s0; k < m_slots; k++) begin
      e.pc   = pc + 64'(4 * (k - s0));
      e.inst = word[32*k +: 32];
      e.last = (k == m_slots - 1);
      mq.push_back(e);
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are set at the negedge; check, take the edge, advance the model.
  task automatic cycle();
    int unsigned cnt;
    bit          exp_v;
    #1;
    cnt = m_count();
    if (!rst_n) begin
      chk("rst_in_ready", 64'(o_in_ready), 64'd0);
      chk("rst_out_valid", 64'(o_out_valid), 64'd0);
    end else begin
      exp_v = (cnt != 0) && !flush;
      chk("count", 64'(o_count), 64'(cnt));
      chk("in_ready", 64'(o_in_ready), 64'(cnt != m_depth));
      chk("out_valid", 64'(o_out_valid), 64'(exp_v));
      chk("no_underflow", 64'(o_out_valid && (o_count == 0)), 64'd0);
      if (exp_v) begin
        chk("out_pc", o_out_pc, mq[0].pc);
        chk("out_inst", 64'(o_out_inst), 64'(mq[0].inst));
      end
    end
    @(posedge clk);
    if (!rst_n || flush) begin
      mq.delete();
    end else begin
      if (out_ready && cnt != 0) void'(mq.pop_front());
      if (in_valid && cnt != m_depth) push_word(in_pc, in_word);
    end
    @(negedge clk);
  endtask

  task automatic rand_traffic(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_pc     = {$urandom, $urandom} & ~64'h3;
      in_word   = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end
    flush = 1'b0;
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    sel = 1'b0; rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_word = '0;
    m_depth = 4; m_slots = 2;
    @(negedge clk);
    cycle();
    cycle();
    rst_n = 1'b1;
    #1;
    chk("reset_out_pc", o_out_pc, 64'd0);
    chk("reset_out_inst", 64'(o_out_inst), 64'd0);

    // 1. one word from an even slot
    out_ready = 1'b1; in_valid = 1'b1;
    in_pc = 64'h1000; in_word = 128'hBBBB0002_AAAA0001;
    cycle();
    in_valid = 1'b0;
    repeat (3) cycle();

    // 2. odd-aligned PC: only the upper slot
    in_valid = 1'b1; in_pc = 64'h2004;
    cycle();
    in_valid = 1'b0;
    repeat (3) cycle();

    // 3. fill while decode stalls, fifth word refused, then drain
    out_ready = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_pc    = 64'h6000 + 64'(8 * i);
      in_word  = {64'd0, $urandom, $urandom};
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (9) cycle();

    // 4. stall for three cycles in the middle of a word
    in_valid = 1'b1; in_pc = 64'h7000; in_word = 128'h77770002_77770001;
    cycle();
    in_valid = 1'b0;
    cycle();
    out_ready = 1'b0;
    repeat (3) cycle();
    out_ready = 1'b1;
    repeat (3) cycle();

    // 5. flush after the first slot, with a word offered in the same cycle
    in_valid = 1'b1; in_pc = 64'h3000; in_word = 128'h33330002_33330001;
    cycle();
    in_valid = 1'b0;
    cycle();
    flush = 1'b1; in_valid = 1'b1; in_pc = 64'h3800; in_word = 128'h38380002_38380001;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    cycle();
    in_valid = 1'b1; in_pc = 64'h4000; in_word = 128'h44440002_44440001;
    cycle();
    in_valid = 1'b0;
    repeat (3) cycle();

    // 6. reset with three words queued
    out_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_pc    = 64'h8000 + 64'(8 * i);
      in_word  = {64'd0, $urandom, $urandom};
      cycle();
    end
    in_valid = 1'b0; rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    out_ready = 1'b1;
    cycle();

    rand_traffic(400);

    // Wide-word, two-deep configuration
    sel = 1'b1; rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    m_depth = 2; m_slots = 4;
    mq.delete();
    cycle();
    rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_pc = 64'h5008;
    in_word = 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001;
    cycle();
    in_valid = 1'b0;
    #1;
    chk("wide_first_pc", o_out_pc, 64'h5008);
    chk("wide_first_inst", 64'(o_out_inst), 64'hCCCC0003);
    repeat (3) cycle();

    rand_traffic(250);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
